// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  // Operation phases: wait for operands, shift one bit per cycle, hold the result.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } sub_state_e;

  localparam int unsigned DefaultWidth = 8;

  // Bit-counter width; never below one bit so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// Combinational 1-bit full-subtract cell: a - b - bor_in.
module sub_bit_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bor,
  output logic o_d,
  output logic o_bor
);

  // Difference and borrow-out of a single bit position.
  always_comb begin
    o_d   = i_a ^ i_b ^ i_bor;
    o_bor = (~i_a & i_b) | (~(i_a ^ i_b) & i_bor);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bor_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bor_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  sub_state_e       r_state;
  sub_state_e       w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_bor;
  logic             r_bor_out;
  logic [CntW-1:0]  r_cnt;
  logic             w_d;
  logic             w_bor;
  logic             w_load;
  logic             w_last;

  sub_bit_cell u_cell (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_bor (r_bor),
    .o_d   (w_d),
    .o_bor (w_bor)
  );

  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, handshake outputs and load strobe.
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    w_load       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_load       = 1'b1;
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand/result shift registers, borrow chain and bit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff    <= '0;
      r_bor     <= 1'b0;
      r_bor_out <= 1'b0;
      r_cnt     <= '0;
    end else if (w_load) begin
      r_a_sr <= i_a;
      r_b_sr <= i_b;
      r_bor  <= i_bor_in;
      r_cnt  <= '0;
    end else if (r_state == StShift) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_bor  <= w_bor;
      if (w_last) begin
        r_cnt     <= '0;
        // Separate flop so bor_out stays put while the chain is reused.
        r_bor_out <= w_bor;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_diff    = r_diff;
  assign o_bor_out = r_bor_out;

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Capture operand signs at load; resolve overflow on the final bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= i_a[WIDTH-1];
      r_b_msb <= i_b[WIDTH-1];
    end else if ((r_state == StShift) && w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end
  end

  assign o_ovf = r_ovf;
`else
  // Overflow tracking not built: no sign flops, no ovf port.
`endif

endmodule
